key_entry_ctrl: RTL and testbench



---
 rtl/key_pkg.sv | 27 ++
 rtl/bcd_digit_acc.sv | 53 +++++
 rtl/key_entry_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_key_entry_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the keypad entry path.
//   DIGITS_DEF : default number of BCD digits per operand
//   KEY_*      : decoded key codes delivered on BCDKey
//   state_t    : entry controller state encoding
package key_pkg;

   localparam int DIGITS_DEF = 4;

   localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
   localparam logic [3:0] KEY_PLUS      = 4'd10;
   localparam logic [3:0] KEY_MINUS     = 4'd11;
   localparam logic [3:0] KEY_EQ        = 4'd12;
   localparam logic [3:0] KEY_CLR       = 4'd13;

   typedef enum logic [2:0] {
      ENTER_A,
      OP,
      ENTER_B,
      WAIT,
      SHOW
   } state_t;

   function automatic logic is_op_key(input logic [3:0] k);
      return (k == KEY_PLUS) || (k == KEY_MINUS);
   endfunction

endpackage

// File: rtl/bcd_digit_acc.sv
// BCD operand accumulator: shift register of DIGITS nibbles plus a count of
// significant digits entered so far.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero value and count
//   load       : value <= load_val, count <= significant digits of load_val
//   shift      : append digit at the low end (ignored while full)
//   value      : current operand, BCD
//   full       : count has reached DIGITS
module bcd_digit_acc #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  shift,
   input  logic [3:0]            digit,
   output logic [4*DIGITS-1:0]   value,
   output logic                  full
);

   localparam int CW = $clog2(DIGITS + 1);

   logic [CW-1:0] cnt;

   // Position of the most significant non-zero nibble, plus one.
   function automatic logic [CW-1:0] sig_count(input logic [4*DIGITS-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] != 4'd0) n = CW'(i + 1);
      end
      return n;
   endfunction

   assign full = (cnt == CW'(DIGITS));

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         value <= '0;
         cnt   <= '0;
      end else if (load) begin
         value <= load_val;
         cnt   <= sig_count(load_val);
      end else if (shift && !full) begin
         value <= {value[4*DIGITS-5:0], digit};
         // leading zeros do not consume a digit position
         if (!(value == '0 && digit == 4'd0)) cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/key_entry_ctrl.sv
// Calculator key entry controller. Reads decoded keys from the keypad
// controller, builds two BCD operands, starts the ALU and holds its result.
//   CLK, RESET            : clock, synchronous active-high reset
//   BCDKey, KeyRead       : key code ([0:3], bit 0 = MSB) and key-valid level
//   AluDone/Result/Neg    : ALU completion pulse, BCD magnitude, sign
//   OperandA/B, OpSub     : operands and operation presented to the ALU
//   AluStart              : one-cycle ALU start pulse
//   Display, DispSign     : value and minus sign to show
//   EntryErr              : one-cycle pulse on a rejected key
//
// state   | meaning
// ENTER_A | collecting digits of operand A
// OP      | operator chosen, waiting for first digit of B
// ENTER_B | collecting digits of operand B
// WAIT    | ALU started, waiting for AluDone
// SHOW    | showing the latched ALU result
import key_pkg::*;

module key_entry_ctrl #(
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [0:3]            BCDKey,
   input  logic                  KeyRead,
   input  logic                  AluDone,
   input  logic [4*DIGITS-1:0]   AluResult,
   input  logic                  AluNeg,
   output logic [4*DIGITS-1:0]   OperandA,
   output logic [4*DIGITS-1:0]   OperandB,
   output logic                  OpSub,
   output logic                  AluStart,
   output logic [4*DIGITS-1:0]   Display,
   output logic                  DispSign,
   output logic                  EntryErr
);

   state_t               state, state_nxt;
   logic                 key_read_q;
   logic                 op_sub, op_sub_nxt;
   logic                 alu_start, start_nxt;
   logic                 entry_err, err_nxt;
   logic [4*DIGITS-1:0]  result, result_nxt;
   logic                 res_neg, neg_nxt;

   logic [3:0]           key;
   logic [4*DIGITS-1:0]  key_ext;
   logic                 key_acc, is_digit, is_op;

   logic                 a_clr, a_load, a_shift, a_full;
   logic [4*DIGITS-1:0]  a_load_val, a_value;
   logic                 b_clr, b_load, b_shift, b_full;
   logic [4*DIGITS-1:0]  b_value;

   // BCDKey is declared [0:3] with bit 0 as MSB; positional copy keeps the value
   assign key      = BCDKey;
   assign key_ext  = {{(4*DIGITS-4){1'b0}}, key};
   assign key_acc  = KeyRead && !key_read_q;
   assign is_digit = (key <= KEY_MAX_DIGIT);
   assign is_op    = is_op_key(key);

   bcd_digit_acc #(.DIGITS(DIGITS)) u_acc_a (
      .clk      (CLK),
      .reset    (RESET),
      .clr      (a_clr),
      .load     (a_load),
      .load_val (a_load_val),
      .shift    (a_shift),
      .digit    (key),
      .value    (a_value),
      .full     (a_full)
   );

   bcd_digit_acc #(.DIGITS(DIGITS)) u_acc_b (
      .clk      (CLK),
      .reset    (RESET),
      .clr      (b_clr),
      .load     (b_load),
      .load_val (key_ext),
      .shift    (b_shift),
      .digit    (key),
      .value    (b_value),
      .full     (b_full)
   );

   always_ff @(posedge CLK) begin
      // key_read_q keeps sampling during reset so a level held across reset
      // is not mistaken for a new key afterwards
      key_read_q <= KeyRead;
      if (RESET) begin
         state     <= ENTER_A;
         op_sub    <= 1'b0;
         alu_start <= 1'b0;
         entry_err <= 1'b0;
         result    <= '0;
         res_neg   <= 1'b0;
      end else begin
         state     <= state_nxt;
         op_sub    <= op_sub_nxt;
         alu_start <= start_nxt;
         entry_err <= err_nxt;
         result    <= result_nxt;
         res_neg   <= neg_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      op_sub_nxt = op_sub;
      start_nxt  = 1'b0;
      err_nxt    = 1'b0;
      result_nxt = result;
      neg_nxt    = res_neg;
      a_clr      = 1'b0;
      a_load     = 1'b0;
      a_shift    = 1'b0;
      a_load_val = key_ext;
      b_clr      = 1'b0;
      b_load     = 1'b0;
      b_shift    = 1'b0;

      if (key_acc && key == KEY_CLR) begin
         state_nxt  = ENTER_A;
         op_sub_nxt = 1'b0;
         result_nxt = '0;
         neg_nxt    = 1'b0;
         a_clr      = 1'b1;
         b_clr      = 1'b1;
      end else begin
         unique case (state)
            ENTER_A: if (key_acc) begin
               if (is_digit) begin
                  if (a_full) err_nxt = 1'b1;
                  else        a_shift = 1'b1;
               end else if (is_op) begin
                  op_sub_nxt = (key == KEY_MINUS);
                  state_nxt  = OP;
               end
            end
            OP: if (key_acc) begin
               if (is_digit) begin
                  b_load    = 1'b1;
                  state_nxt = ENTER_B;
               end else if (is_op) begin
                  op_sub_nxt = (key == KEY_MINUS);
               end else if (key == KEY_EQ) begin
                  err_nxt = 1'b1;
               end
            end
            ENTER_B: if (key_acc) begin
               if (is_digit) begin
                  if (b_full) err_nxt = 1'b1;
                  else        b_shift = 1'b1;
               end else if (is_op) begin
                  err_nxt = 1'b1;
               end else if (key == KEY_EQ) begin
                  start_nxt = 1'b1;
                  state_nxt = WAIT;
               end
            end
            WAIT: if (AluDone) begin
               result_nxt = AluResult;
               neg_nxt    = AluNeg;
               state_nxt  = SHOW;
            end
            SHOW: if (key_acc) begin
               if (is_digit) begin
                  a_load    = 1'b1;
                  b_clr     = 1'b1;
                  state_nxt = ENTER_A;
               end else if (is_op) begin
                  if (res_neg) begin
                     // a negative result cannot be fed back as a BCD magnitude
                     err_nxt = 1'b1;
                  end else begin
                     a_load     = 1'b1;
                     a_load_val = result;
                     op_sub_nxt = (key == KEY_MINUS);
                     state_nxt  = OP;
                  end
               end
            end
            default: state_nxt = ENTER_A;
         endcase
      end
   end

   always_comb begin
      Display  = a_value;
      DispSign = 1'b0;
      unique case (state)
         ENTER_B, WAIT: Display = b_value;
         SHOW: begin
            Display  = result;
            DispSign = res_neg;
         end
         default: Display = a_value;
      endcase
   end

   assign OperandA = a_value;
   assign OperandB = b_value;
   assign OpSub    = op_sub;
   assign AluStart = alu_start;
   assign EntryErr = entry_err;

endmodule

// File: tb/tb_key_entry_ctrl.sv
module tb_key_entry_ctrl;

   localparam int ND = 4;
   localparam int MAXV = 10000;
   localparam int MA = 0, MOP = 1, MB = 2, MW = 3, MS = 4;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic [0:3]    BCDKey = '0;
   logic          KeyRead = 1'b0;
   logic          AluDone = 1'b0;
   logic [15:0]   AluResult = '0;
   logic          AluNeg = 1'b0;
   logic [15:0]   OperandA, OperandB, Display;
   logic          OpSub, AluStart, DispSign, EntryErr;

   int key_i = 0;
   int alu_res_int = 0;
   int checks = 0;
   int errors = 0;
   int err_pulses = 0;

   always #5 CLK = ~CLK;

   key_entry_ctrl #(.DIGITS(ND)) dut (
      .CLK(CLK), .RESET(RESET), .BCDKey(BCDKey), .KeyRead(KeyRead),
      .AluDone(AluDone), .AluResult(AluResult), .AluNeg(AluNeg),
      .OperandA(OperandA), .OperandB(OperandB), .OpSub(OpSub),
      .AluStart(AluStart), .Display(Display), .DispSign(DispSign),
      .EntryErr(EntryErr)
   );

   // ---------------- behavioural reference (decimal integers) -------------
   int m_mode, m_a, m_b, m_ac, m_bc, m_res;
   bit m_neg, m_sub, m_start, m_err, m_kq;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int ndig(input int v);
      int n;
      n = 0;
      while (v > 0) begin n++; v = v / 10; end
      return n;
   endfunction

   task automatic model_clear();
      m_mode = MA; m_a = 0; m_b = 0; m_ac = 0; m_bc = 0;
      m_res = 0; m_neg = 0; m_sub = 0;
   endtask

   task automatic model_step();
      bit acc;
      int k;
      k = key_i;
      m_start = 0;
      m_err = 0;
      if (RESET) begin
         model_clear();
         m_kq = KeyRead;
         return;
      end
      acc = KeyRead && !m_kq;
      m_kq = KeyRead;
      if (acc && k == 13) begin
         model_clear();
         return;
      end
      case (m_mode)
         MA: if (acc) begin
            if (k <= 9) begin
               if (m_ac == ND) m_err = 1;
               else begin
                  if (!(m_a == 0 && k == 0)) m_ac++;
                  m_a = (m_a * 10 + k) % MAXV;
               end
            end else if (k == 10 || k == 11) begin
               m_sub = (k == 11); m_mode = MOP;
            end
         end
         MOP: if (acc) begin
            if (k <= 9) begin
               m_b = k; m_bc = (k != 0); m_mode = MB;
            end else if (k == 10 || k == 11) m_sub = (k == 11);
            else if (k == 12) m_err = 1;
         end
         MB: if (acc) begin
            if (k <= 9) begin
               if (m_bc == ND) m_err = 1;
               else begin
                  if (!(m_b == 0 && k == 0)) m_bc++;
                  m_b = (m_b * 10 + k) % MAXV;
               end
            end else if (k == 10 || k == 11) m_err = 1;
            else if (k == 12) begin m_mode = MW; m_start = 1; end
         end
         MW: if (AluDone) begin
            m_res = alu_res_int; m_neg = AluNeg; m_mode = MS;
         end
         default: if (acc) begin
            if (k <= 9) begin
               m_a = k; m_ac = (k != 0); m_b = 0; m_bc = 0; m_mode = MA;
            end else if (k == 10 || k == 11) begin
               if (m_neg) m_err = 1;
               else begin
                  m_a = m_res; m_ac = ndig(m_res); m_sub = (k == 11); m_mode = MOP;
               end
            end
         end
      endcase
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      int ed;
      @(posedge CLK);
      model_step();
      #1;
      if (EntryErr === 1'b1) err_pulses++;
      ed = (m_mode == MA || m_mode == MOP) ? m_a : (m_mode == MS) ? m_res : m_b;
      chk("OperandA", OperandA, to_bcd(m_a));
      chk("OperandB", OperandB, to_bcd(m_b));
      chk("OpSub", OpSub, m_sub);
      chk("AluStart", AluStart, m_start);
      chk("EntryErr", EntryErr, m_err);
      chk("Display", Display, to_bcd(ed));
      chk("DispSign", DispSign, (m_mode == MS) && m_neg);
   endtask

   task automatic set_key(input int k);
      key_i = k;
      BCDKey = 4'(k);
   endtask

   task automatic press(input int k, input int hold);
      set_key(k);
      KeyRead = 1'b1;
      repeat (hold) cycle();
      KeyRead = 1'b0;
      cycle();
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      cycle();
      cycle();
      RESET = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit kr; int key; bit done; int res; bit neg;
      logic [15:0] ea; logic [15:0] eb; logic [15:0] ed;
      bit esub; bit estart; bit eerr; bit esign;
   } vec_t;

   vec_t vt[26];

   initial begin
      int ep;
      int d;
      int k;

      vt[0]  = '{1, 1, 0, 0, 0, 16'h0001, 16'h0000, 16'h0001, 0, 0, 0, 0};
      vt[1]  = '{1, 1, 0, 0, 0, 16'h0001, 16'h0000, 16'h0001, 0, 0, 0, 0};
      vt[2]  = '{0, 1, 0, 0, 0, 16'h0001, 16'h0000, 16'h0001, 0, 0, 0, 0};
      vt[3]  = '{1, 2, 0, 0, 0, 16'h0012, 16'h0000, 16'h0012, 0, 0, 0, 0};
      vt[4]  = '{0, 2, 0, 0, 0, 16'h0012, 16'h0000, 16'h0012, 0, 0, 0, 0};
      vt[5]  = '{1, 10, 0, 0, 0, 16'h0012, 16'h0000, 16'h0012, 0, 0, 0, 0};
      vt[6]  = '{0, 10, 0, 0, 0, 16'h0012, 16'h0000, 16'h0012, 0, 0, 0, 0};
      vt[7]  = '{1, 3, 0, 0, 0, 16'h0012, 16'h0003, 16'h0003, 0, 0, 0, 0};
      vt[8]  = '{0, 3, 0, 0, 0, 16'h0012, 16'h0003, 16'h0003, 0, 0, 0, 0};
      vt[9]  = '{1, 12, 0, 0, 0, 16'h0012, 16'h0003, 16'h0003, 0, 1, 0, 0};
      vt[10] = '{0, 12, 0, 0, 0, 16'h0012, 16'h0003, 16'h0003, 0, 0, 0, 0};
      vt[11] = '{1, 5, 0, 0, 0, 16'h0012, 16'h0003, 16'h0003, 0, 0, 0, 0};
      vt[12] = '{0, 5, 0, 0, 0, 16'h0012, 16'h0003, 16'h0003, 0, 0, 0, 0};
      vt[13] = '{0, 0, 1, 15, 0, 16'h0012, 16'h0003, 16'h0015, 0, 0, 0, 0};
      vt[14] = '{0, 0, 0, 0, 0, 16'h0012, 16'h0003, 16'h0015, 0, 0, 0, 0};
      vt[15] = '{1, 11, 0, 0, 0, 16'h0015, 16'h0003, 16'h0015, 1, 0, 0, 0};
      vt[16] = '{0, 11, 0, 0, 0, 16'h0015, 16'h0003, 16'h0015, 1, 0, 0, 0};
      vt[17] = '{1, 5, 0, 0, 0, 16'h0015, 16'h0005, 16'h0005, 1, 0, 0, 0};
      vt[18] = '{0, 5, 0, 0, 0, 16'h0015, 16'h0005, 16'h0005, 1, 0, 0, 0};
      vt[19] = '{1, 12, 0, 0, 0, 16'h0015, 16'h0005, 16'h0005, 1, 1, 0, 0};
      vt[20] = '{0, 12, 0, 0, 0, 16'h0015, 16'h0005, 16'h0005, 1, 0, 0, 0};
      vt[21] = '{0, 0, 1, 10, 1, 16'h0015, 16'h0005, 16'h0010, 1, 0, 0, 1};
      vt[22] = '{1, 10, 0, 0, 0, 16'h0015, 16'h0005, 16'h0010, 1, 0, 1, 1};
      vt[23] = '{0, 10, 0, 0, 0, 16'h0015, 16'h0005, 16'h0010, 1, 0, 0, 1};
      vt[24] = '{1, 13, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0};
      vt[25] = '{0, 13, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0};

      m_kq = 0;
      model_clear();
      do_reset();
      chk("reset_A", OperandA, 16'h0000);
      chk("reset_Display", Display, 16'h0000);

      for (int i = 0; i < 26; i++) begin
         KeyRead = vt[i].kr;
         set_key(vt[i].key);
         AluDone = vt[i].done;
         alu_res_int = vt[i].res;
         AluResult = to_bcd(vt[i].res);
         AluNeg = vt[i].neg;
         cycle();
         chk($sformatf("tbl%0d_A", i), OperandA, vt[i].ea);
         chk($sformatf("tbl%0d_B", i), OperandB, vt[i].eb);
         chk($sformatf("tbl%0d_Disp", i), Display, vt[i].ed);
         chk($sformatf("tbl%0d_Sub", i), OpSub, vt[i].esub);
         chk($sformatf("tbl%0d_Start", i), AluStart, vt[i].estart);
         chk($sformatf("tbl%0d_Err", i), EntryErr, vt[i].eerr);
         chk($sformatf("tbl%0d_Sign", i), DispSign, vt[i].esign);
      end
      AluDone = 1'b0;
      AluNeg = 1'b0;

      // held keys give one shift each
      do_reset();
      press(1, 5); press(2, 5); press(3, 5);
      chk("held_A", OperandA, 16'h0123);
      chk("held_Disp", Display, 16'h0123);

      // leading zeros and overflow, twice
      for (int run = 0; run < 2; run++) begin
         press(13, 1);
         ep = err_pulses;
         press(0, 2); press(0, 2); press(7, 2); press(4, 2);
         press(5, 2); press(6, 2);
         chk("lz_no_err", err_pulses - ep, 0);
         press(9, 2);
         chk("lz_A", OperandA, 16'h7456);
         chk("lz_err_once", err_pulses - ep, 1);
      end

      // clear in the middle of operand B
      press(13, 1);
      press(4, 1); press(2, 1); press(10, 1); press(7, 1);
      chk("clrB_pre_A", OperandA, 16'h0042);
      chk("clrB_pre_B", OperandB, 16'h0007);
      set_key(13);
      KeyRead = 1'b1;
      cycle();
      chk("clrB_A", OperandA, 16'h0000);
      chk("clrB_B", OperandB, 16'h0000);
      chk("clrB_Disp", Display, 16'h0000);
      KeyRead = 1'b0;
      cycle();

      // reset collides with a new key and AluDone
      press(1, 1); press(10, 1); press(2, 1); press(12, 1);
      RESET = 1'b1;
      set_key(5);
      KeyRead = 1'b1;
      AluDone = 1'b1;
      alu_res_int = 77;
      AluResult = to_bcd(77);
      cycle();
      RESET = 1'b0;
      AluDone = 1'b0;
      repeat (3) cycle();
      chk("rstkey_A", OperandA, 16'h0000);
      chk("rstkey_Disp", Display, 16'h0000);
      chk("rstkey_Sign", DispSign, 1'b0);
      KeyRead = 1'b0;
      cycle();
      KeyRead = 1'b1;
      cycle();
      chk("rstkey_after_A", OperandA, 16'h0005);
      KeyRead = 1'b0;
      cycle();

      // randomized traffic against the reference
      for (int n = 0; n < 4000; n++) begin
         if (KeyRead) begin
            if ($urandom_range(0, 1) == 0) KeyRead = 1'b0;
         end else if ($urandom_range(0, 9) < 4) begin
            k = $urandom_range(0, 15);
            if (k == 13 && $urandom_range(0, 3) != 0) k = $urandom_range(0, 9);
            set_key(k);
            KeyRead = 1'b1;
         end
         AluDone = ($urandom_range(0, 7) == 0);
         d = (($urandom_range(0, 1) == 0) ? $urandom_range(0, 99) : $urandom_range(0, MAXV - 1));
         alu_res_int = d;
         AluResult = to_bcd(d);
         AluNeg = ($urandom_range(0, 2) == 0);
         RESET = ($urandom_range(0, 499) == 0);
         cycle();
      end
      RESET = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
